// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: owns the single RegFile write port and shares it
// between the pipeline writeback stage and two buffered side-band requesters
// (button and timer). A bounded-wait counter caps how long a pending side
// write may lose to the pipeline, and a round-robin bit keeps the two side
// requesters fair.
// Optional statistics counters are enabled with `define REGFILE_ARB_STATS_EN.
module regfile_write_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter logic [4:0]  BTN_REG  = 5'd25,
  parameter logic [4:0]  TMR_REG  = 5'd28,
  parameter logic [4:0]  ERR_REG  = 5'd30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        wb_error,
  input  logic        btn_req,
  input  logic [31:0] btn_data,
  input  logic        tmr_req,
  input  logic [31:0] tmr_data,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic        pipe_stall,
  output logic        btn_ack,
  output logic        tmr_ack
`ifdef REGFILE_ARB_STATS_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] side_writes
`endif
);

  localparam int unsigned CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_PIPE,
    GNT_BTN,
    GNT_TMR
  } grant_t;

  grant_t          grant;
  logic            btn_pend;
  logic            tmr_pend;
  logic [31:0]     btn_buf;
  logic [31:0]     tmr_buf;
  logic            rr_last;
  logic [CW-1:0]   wait_cnt;
  logic            any_pend;
  logic            side_ok;
  logic            side_grant;
  logic [4:0]      pipe_reg;

  // Grant decision from current state; reset forces the port idle.
  always_comb begin
    any_pend = btn_pend | tmr_pend;
    side_ok  = any_pend & (~wb_we | (wait_cnt == WAIT_MAX));
    grant    = GNT_IDLE;
    if (reset) begin
      grant = GNT_IDLE;
    end else if (side_ok) begin
      if (btn_pend && tmr_pend) begin
        grant = rr_last ? GNT_BTN : GNT_TMR;
      end else begin
        grant = btn_pend ? GNT_BTN : GNT_TMR;
      end
    end else if (wb_we) begin
      grant = GNT_PIPE;
    end
  end

  // Drive the RegFile write port and the pipeline stall from the grant.
  always_comb begin
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = '0;
    data_writeReg    = '0;
    pipe_stall       = 1'b0;
    side_grant       = 1'b0;
    pipe_reg         = wb_error ? ERR_REG : wb_reg;
    case (grant)
      GNT_BTN: begin
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = BTN_REG;
        data_writeReg    = btn_buf;
        pipe_stall       = wb_we;
        side_grant       = 1'b1;
      end
      GNT_TMR: begin
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = TMR_REG;
        data_writeReg    = tmr_buf;
        pipe_stall       = wb_we;
        side_grant       = 1'b1;
      end
      GNT_PIPE: begin
        ctrl_writeEnable = (pipe_reg != 5'd0);
        ctrl_writeReg    = pipe_reg;
        data_writeReg    = wb_data;
      end
      default: begin
        ctrl_writeEnable = 1'b0;
      end
    endcase
  end

  // Side buffers, pend flags, round-robin bit and acks.
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_pend <= 1'b0;
      tmr_pend <= 1'b0;
      btn_buf  <= '0;
      tmr_buf  <= '0;
      rr_last  <= 1'b0;
      btn_ack  <= 1'b0;
      tmr_ack  <= 1'b0;
    end else begin
      btn_ack <= (grant == GNT_BTN);
      tmr_ack <= (grant == GNT_TMR);
      // A same-cycle request overrides the clear below (last assignment wins).
      if (grant == GNT_BTN) btn_pend <= 1'b0;
      if (grant == GNT_TMR) tmr_pend <= 1'b0;
      if (btn_req) begin
        btn_pend <= 1'b1;
        btn_buf  <= btn_data;
      end
      if (tmr_req) begin
        tmr_pend <= 1'b1;
        tmr_buf  <= tmr_data;
      end
      if (grant == GNT_BTN) begin
        rr_last <= 1'b0;
      end else if (grant == GNT_TMR) begin
        rr_last <= 1'b1;
      end
    end
  end

  // Bounded-wait counter: counts pipeline wins over a pending side write.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (side_grant || !any_pend) begin
      wait_cnt <= '0;
    end else if (grant == GNT_PIPE && wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

`ifdef REGFILE_ARB_STATS_EN
  // Saturating statistics counters for stalls and side-band writes.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= '0;
      side_writes  <= '0;
    end else begin
      if (pipe_stall && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
      if (side_grant && side_writes != 16'hFFFF) side_writes <= side_writes + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: a directed vector table for
// the documented scenarios, a hand-written reset-while-pending sequence, and
// randomized traffic checked against a behavioural reference model.
module tb_regfile_write_arbiter;

  localparam int MW = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic [31:0] wb_data = '0;
  logic        wb_error = 1'b0;
  logic        btn_req = 1'b0;
  logic [31:0] btn_data = '0;
  logic        tmr_req = 1'b0;
  logic [31:0] tmr_data = '0;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        pipe_stall;
  logic        btn_ack;
  logic        tmr_ack;

  always #5 clock = ~clock;

  regfile_write_arbiter #(
    .MAX_WAIT(MW),
    .BTN_REG(5'd25),
    .TMR_REG(5'd28),
    .ERR_REG(5'd30)
  ) dut (
    .clock(clock),
    .reset(reset),
    .wb_we(wb_we),
    .wb_reg(wb_reg),
    .wb_data(wb_data),
    .wb_error(wb_error),
    .btn_req(btn_req),
    .btn_data(btn_data),
    .tmr_req(tmr_req),
    .tmr_data(tmr_data),
    .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg),
    .pipe_stall(pipe_stall),
    .btn_ack(btn_ack),
    .tmr_ack(tmr_ack)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: index 0 = button, 1 = timer.
  bit          m_pend [2];
  logic [31:0] m_buf  [2];
  int          m_last;      // source served most recently
  int          m_lost;      // consecutive cycles the side entry lost to the pipeline
  bit          m_ack  [2];
  bit          e_side;
  int          e_src;
  bit          e_we;
  logic [4:0]  e_reg;
  logic [31:0] e_data;
  bit          e_stall;

  task automatic model_reset();
    m_pend = '{0, 0};
    m_buf  = '{32'h0, 32'h0};
    m_last = 0;
    m_lost = 0;
    m_ack  = '{0, 0};
  endtask

  task automatic model_eval();
    bit any;
    any = m_pend[0] || m_pend[1];
    e_side = 0; e_src = 0; e_we = 0; e_reg = '0; e_data = '0; e_stall = 0;
    if (!reset) begin
      if (any && (!wb_we || m_lost >= MW)) begin
        e_side = 1;
        if (m_pend[0] && m_pend[1]) e_src = 1 - m_last;
        else e_src = m_pend[1] ? 1 : 0;
        e_we    = 1;
        e_reg   = (e_src == 1) ? 5'd28 : 5'd25;
        e_data  = m_buf[e_src];
        e_stall = wb_we;
      end else if (wb_we) begin
        e_reg  = wb_error ? 5'd30 : wb_reg;
        e_data = wb_data;
        e_we   = (e_reg != 5'd0);
      end
    end
  endtask

  task automatic model_step();
    bit any;
    if (reset) begin
      model_reset();
      return;
    end
    any = m_pend[0] || m_pend[1];
    m_ack = '{0, 0};
    if (e_side) begin
      m_pend[e_src] = 0;
      m_last = e_src;
      m_lost = 0;
      m_ack[e_src] = 1;
    end else if (any && wb_we) begin
      if (m_lost < MW) m_lost++;
    end else if (!any) begin
      m_lost = 0;
    end
    if (btn_req) begin m_pend[0] = 1; m_buf[0] = btn_data; end
    if (tmr_req) begin m_pend[1] = 1; m_buf[1] = tmr_data; end
  endtask

  // Called #1 after the driving negedge: evaluate model, take the edge, return at next negedge.
  task automatic finish_cycle();
    model_eval();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic cmp_model();
    chk("rand_we", ctrl_writeEnable, e_we);
    chk("rand_stall", pipe_stall, e_stall);
    chk("rand_btn_ack", btn_ack, m_ack[0]);
    chk("rand_tmr_ack", tmr_ack, m_ack[1]);
    if (!reset) begin
      chk("rand_reg", ctrl_writeReg, e_reg);
      chk("rand_data", data_writeReg, e_data);
    end
  endtask

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        wb_error;
    logic        btn_req;
    logic [31:0] btn_data;
    logic        tmr_req;
    logic [31:0] tmr_data;
    logic        x_we;
    logic [4:0]  x_reg;
    logic [31:0] x_data;
    logic        x_stall;
    logic        x_back;
    logic        x_tack;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic we, logic [4:0] r, logic [31:0] d, logic er,
                              logic br, logic [31:0] bd, logic tr, logic [31:0] td,
                              logic xwe, logic [4:0] xr, logic [31:0] xd, logic xs,
                              logic xb, logic xt);
    vec_t v;
    v.wb_we = we; v.wb_reg = r; v.wb_data = d; v.wb_error = er;
    v.btn_req = br; v.btn_data = bd; v.tmr_req = tr; v.tmr_data = td;
    v.x_we = xwe; v.x_reg = xr; v.x_data = xd; v.x_stall = xs;
    v.x_back = xb; v.x_tack = xt;
    return v;
  endfunction

  initial begin
    model_reset();
    // Idle port, button pulse lands next cycle, ack the cycle after.
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h3, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 25, 32'h3, 0, 0, 0));
    // Both pulse together with rr_last=0: timer first, then button.
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h11, 1, 32'h22, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 28, 32'h22, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 25, 32'h11, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // Continuous writeback vs timer: 4 pipeline wins, then a stalled side write.
    tbl.push_back(mk(1, 5, 32'hA5, 0, 0, 0, 1, 32'd1000, 1, 5, 32'hA5, 0, 0, 0));
    repeat (4) tbl.push_back(mk(1, 5, 32'hA5, 0, 0, 0, 0, 0, 1, 5, 32'hA5, 0, 0, 0));
    tbl.push_back(mk(1, 5, 32'hA5, 0, 0, 0, 0, 0, 1, 28, 32'd1000, 1, 0, 0));
    tbl.push_back(mk(1, 5, 32'hA5, 0, 0, 0, 0, 0, 1, 5, 32'hA5, 0, 0, 1));
    // Error redirect, then writes to reg 0 are suppressed.
    tbl.push_back(mk(1, 7, 32'd1, 1, 0, 0, 0, 0, 1, 30, 32'd1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 32'h55, 0, 0, 0, 0, 0, 0, 0, 32'h55, 0, 0, 0));
    // Button overwritten while blocked: only the latest value lands, one ack.
    tbl.push_back(mk(1, 9, 32'h99, 0, 1, 32'h1, 0, 0, 1, 9, 32'h99, 0, 0, 0));
    tbl.push_back(mk(1, 9, 32'h99, 0, 1, 32'h2, 0, 0, 1, 9, 32'h99, 0, 0, 0));
    repeat (3) tbl.push_back(mk(1, 9, 32'h99, 0, 0, 0, 0, 0, 1, 9, 32'h99, 0, 0, 0));
    tbl.push_back(mk(1, 9, 32'h99, 0, 0, 0, 0, 0, 1, 25, 32'h2, 1, 0, 0));
    tbl.push_back(mk(1, 9, 32'h99, 0, 0, 0, 0, 0, 1, 9, 32'h99, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    @(negedge clock);
    repeat (2) begin #1; finish_cycle(); end
    #1;
    chk("reset_we", ctrl_writeEnable, 0);
    chk("reset_stall", pipe_stall, 0);
    finish_cycle();
    reset = 1'b0;
    #1;
    chk("post_reset_acks", {btn_ack, tmr_ack}, 2'b00);
    chk("post_reset_we", ctrl_writeEnable, 0);
    finish_cycle();

    for (int i = 0; i < tbl.size(); i++) begin
      wb_we = tbl[i].wb_we; wb_reg = tbl[i].wb_reg; wb_data = tbl[i].wb_data;
      wb_error = tbl[i].wb_error; btn_req = tbl[i].btn_req; btn_data = tbl[i].btn_data;
      tmr_req = tbl[i].tmr_req; tmr_data = tbl[i].tmr_data;
      #1;
      chk($sformatf("vec%0d_we", i), ctrl_writeEnable, tbl[i].x_we);
      chk($sformatf("vec%0d_reg", i), ctrl_writeReg, tbl[i].x_reg);
      chk($sformatf("vec%0d_data", i), data_writeReg, tbl[i].x_data);
      chk($sformatf("vec%0d_stall", i), pipe_stall, tbl[i].x_stall);
      chk($sformatf("vec%0d_btn_ack", i), btn_ack, tbl[i].x_back);
      chk($sformatf("vec%0d_tmr_ack", i), tmr_ack, tbl[i].x_tack);
      finish_cycle();
    end

    // Reset while both sides are pending and the wait counter sits at 3.
    wb_we = 1; wb_reg = 5'd9; wb_data = 32'h99; wb_error = 0;
    btn_req = 1; btn_data = 32'hB0; tmr_req = 1; tmr_data = 32'hC0;
    #1; finish_cycle();
    btn_req = 0; tmr_req = 0;
    repeat (3) begin #1; finish_cycle(); end
    reset = 1;
    repeat (2) begin
      #1;
      chk("rst_pend_we", ctrl_writeEnable, 0);
      chk("rst_pend_stall", pipe_stall, 0);
      finish_cycle();
    end
    reset = 0; wb_we = 0;
    repeat (3) begin
      #1;
      chk("after_rst_we", ctrl_writeEnable, 0);
      chk("after_rst_stall", pipe_stall, 0);
      chk("after_rst_acks", {btn_ack, tmr_ack}, 2'b00);
      finish_cycle();
    end
    btn_req = 1; btn_data = 32'h77;
    #1; finish_cycle();
    btn_req = 0;
    #1;
    chk("after_rst_new_reg", ctrl_writeReg, 5'd25);
    chk("after_rst_new_data", data_writeReg, 32'h77);
    finish_cycle();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(0, 199) == 0);
      wb_we    = ($urandom_range(0, 9) < 6);
      wb_reg   = 5'($urandom_range(0, 31));
      wb_data  = $urandom;
      wb_error = ($urandom_range(0, 9) == 0);
      btn_req  = ($urandom_range(0, 4) == 0);
      btn_data = $urandom;
      tmr_req  = ($urandom_range(0, 4) == 0);
      tmr_data = $urandom;
      #1;
      model_eval();
      cmp_model();
      finish_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
